// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: request/data in, memory write port and status out.
// The master drives requests and the synchronized read pointer; the slave is the write controller.
interface async_fifo_wr_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // A write is taken on a posedge where write_enable=1 and wfull=0; no ready signal is needed,
  // because mem_we reports acceptance combinationally in the same cycle.
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] afull_value;
  logic [ADDR_WIDTH:0]   rptr_gray_sync;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic                  wfull;
  logic                  wr_almost_full;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   wr_level;
  logic [ADDR_WIDTH:0]   fifo_write_count;

  modport master (
    output write_enable, write_data, afull_value, rptr_gray_sync,
    input  mem_we, mem_waddr, mem_wdata, wptr_gray, wfull, wr_almost_full,
           overflow, wr_level, fifo_write_count
  );

  modport slave (
    input  write_enable, write_data, afull_value, rptr_gray_sync,
    output mem_we, mem_waddr, mem_wdata, wptr_gray, wfull, wr_almost_full,
           overflow, wr_level, fifo_write_count
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: accepts writes, drives the memory write port,
// publishes a Gray write pointer and derives full/almost-full/level from the synced read pointer.
module async_fifo_wr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                wclk,
  input  logic                sw_rst,
  async_fifo_wr_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] wptr_bin;
  logic [ADDR_WIDTH:0] wptr_bin_next;
  logic [ADDR_WIDTH:0] wptr_gray_next;
  logic [ADDR_WIDTH:0] rptr_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] free_next;
  logic [ADDR_WIDTH:0] full_pattern;
  logic                accept;
  logic                full_next;
  logic                almost_full_next;
  logic                overflow_next;

  assign accept        = bus.write_enable & ~bus.wfull & ~sw_rst;
  assign bus.mem_we    = accept;
  assign bus.mem_waddr = wptr_bin[ADDR_WIDTH-1:0];
  assign bus.mem_wdata = bus.write_data;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rptr_bin[i] = ^(bus.rptr_gray_sync >> i);
    end
  end

  // Flags are look-ahead: they describe the state after this edge, so wfull rises with the
  // write that fills the last slot rather than one cycle later.
  always_comb begin
    wptr_bin_next    = wptr_bin + {{ADDR_WIDTH{1'b0}}, accept};
    wptr_gray_next   = (wptr_bin_next >> 1) ^ wptr_bin_next;
    level_next       = wptr_bin_next - rptr_bin;
    free_next        = DEPTH - level_next;
    full_pattern     = {~bus.rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                        bus.rptr_gray_sync[ADDR_WIDTH-2:0]};
    full_next        = (wptr_gray_next == full_pattern);
    almost_full_next = (free_next <= {1'b0, bus.afull_value});
    overflow_next    = bus.write_enable & bus.wfull & ~sw_rst;
  end

  always_ff @(posedge wclk) begin
    if (sw_rst) begin
      wptr_bin             <= '0;
      bus.wptr_gray        <= '0;
      bus.wfull            <= 1'b0;
      bus.wr_almost_full   <= 1'b0;
      bus.overflow         <= 1'b0;
      bus.wr_level         <= '0;
      bus.fifo_write_count <= '0;
    end else begin
      wptr_bin             <= wptr_bin_next;
      bus.wptr_gray        <= wptr_gray_next;
      bus.wfull            <= full_next;
      bus.wr_almost_full   <= almost_full_next;
      bus.overflow         <= overflow_next;
      bus.wr_level         <= level_next;
      bus.fifo_write_count <= bus.fifo_write_count + {{ADDR_WIDTH{1'b0}}, accept};
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for the async FIFO write controller: fill, overflow, full release,
// pointer wrap, reset mid-operation and the afull_value=0 boundary.
module tb_async_fifo_wr_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  logic wclk = 1'b0;
  logic sw_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [AW:0] wp;

  async_fifo_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  async_fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .wclk   (wclk),
    .sw_rst (sw_rst),
    .bus    (bus.slave)
  );

  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic do_reset();
    sw_rst = 1'b1;
    bus.write_enable = 1'b0;
    tick();
    sw_rst = 1'b0;
  endtask

  // One accepted write; checks the combinational memory port before the edge.
  task automatic write_one(input logic [DW-1:0] data, input logic [AW-1:0] addr);
    bus.write_enable = 1'b1;
    bus.write_data   = data;
    #1;
    check("wr_mem_we", 64'(bus.mem_we), 64'd1);
    check("wr_mem_waddr", 64'(bus.mem_waddr), 64'(addr));
    check("wr_mem_wdata", 64'(bus.mem_wdata), 64'(data));
    tick();
    bus.write_enable = 1'b0;
  endtask

  initial begin
    sw_rst = 1'b1;
    bus.write_enable   = 1'b0;
    bus.write_data     = '0;
    bus.afull_value    = 5'd4;
    bus.rptr_gray_sync = '0;
    @(negedge wclk);

    // 1. reset then idle
    tick();
    sw_rst = 1'b0;
    tick();
    check("rst_wfull", 64'(bus.wfull), 64'd0);
    check("rst_afull", 64'(bus.wr_almost_full), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_level", 64'(bus.wr_level), 64'd0);
    check("rst_count", 64'(bus.fifo_write_count), 64'd0);
    check("rst_wptr_gray", 64'(bus.wptr_gray), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);

    // 2. fill 32 words; almost-full from level 28, full at 32
    for (int i = 0; i < 32; i++) begin
      write_one(32'h1000 + i, 5'(i));
      check("fill_level", 64'(bus.wr_level), 64'(i + 1));
      check("fill_afull", 64'(bus.wr_almost_full), 64'((i + 1) >= 28));
      check("fill_wfull", 64'(bus.wfull), 64'((i + 1) == 32));
      check("fill_count", 64'(bus.fifo_write_count), 64'(i + 1));
    end
    check("full_wptr_gray", 64'(bus.wptr_gray), 64'b110000);

    // 3. three illegal writes while full
    for (int i = 0; i < 3; i++) begin
      bus.write_enable = 1'b1;
      bus.write_data   = 32'hdead0000 + i;
      #1;
      check("ovf_mem_we", 64'(bus.mem_we), 64'd0);
      tick();
      check("ovf_pulse", 64'(bus.overflow), 64'd1);
      check("ovf_count", 64'(bus.fifo_write_count), 64'd32);
      check("ovf_wptr_gray", 64'(bus.wptr_gray), 64'b110000);
    end
    bus.write_enable = 1'b0;
    tick();
    check("ovf_clear", 64'(bus.overflow), 64'd0);

    // 4. read pointer advances to 4 while a write is presented: the write is still rejected
    bus.rptr_gray_sync = 6'b000110;
    bus.write_enable   = 1'b1;
    #1;
    check("rel_mem_we", 64'(bus.mem_we), 64'd0);
    tick();
    bus.write_enable = 1'b0;
    check("rel_wfull", 64'(bus.wfull), 64'd0);
    check("rel_level", 64'(bus.wr_level), 64'd28);
    check("rel_afull", 64'(bus.wr_almost_full), 64'd1);
    check("rel_overflow", 64'(bus.overflow), 64'd1);
    check("rel_count", 64'(bus.fifo_write_count), 64'd32);
    for (int i = 0; i < 4; i++) begin
      write_one(32'h2000 + i, 5'(i));
      check("refill_wfull", 64'(bus.wfull), 64'(i == 3));
    end
    check("refill_wptr_gray", 64'(bus.wptr_gray), 64'b110110);
    check("refill_count", 64'(bus.fifo_write_count), 64'd36);

    // 5. wrap: 64 writes with the read pointer trailing so the level stays at 2
    do_reset();
    bus.rptr_gray_sync = '0;
    write_one(32'h3000, 5'd0);
    write_one(32'h3001, 5'd1);
    wp = 6'd2;
    for (int i = 0; i < 64; i++) begin
      bus.rptr_gray_sync = gray(wp - 6'd1);
      write_one(32'h4000 + i, wp[AW-1:0]);
      wp = wp + 6'd1;
      check("wrap_wptr_gray", 64'(bus.wptr_gray), 64'(gray(wp)));
      check("wrap_wfull", 64'(bus.wfull), 64'd0);
      check("wrap_level", 64'(bus.wr_level), 64'd2);
      if (wp == 6'd0) check("wrap_zero", 64'(bus.wptr_gray), 64'b000000);
      if (wp == 6'd63) check("wrap_pre", 64'(bus.wptr_gray), 64'b100000);
    end

    // 6. reset concurrent with a write at level 17
    do_reset();
    bus.rptr_gray_sync = '0;
    for (int i = 0; i < 17; i++) write_one(32'h5000 + i, 5'(i));
    check("pre_rst_level", 64'(bus.wr_level), 64'd17);
    sw_rst = 1'b1;
    bus.write_enable = 1'b1;
    #1;
    check("rstw_mem_we", 64'(bus.mem_we), 64'd0);
    tick();
    sw_rst = 1'b0;
    bus.write_enable = 1'b0;
    check("rstw_level", 64'(bus.wr_level), 64'd0);
    check("rstw_count", 64'(bus.fifo_write_count), 64'd0);
    check("rstw_wptr_gray", 64'(bus.wptr_gray), 64'd0);
    check("rstw_wfull", 64'(bus.wfull), 64'd0);
    check("rstw_afull", 64'(bus.wr_almost_full), 64'd0);
    check("rstw_overflow", 64'(bus.overflow), 64'd0);
    write_one(32'h6000, 5'd0);
    check("post_rst_level", 64'(bus.wr_level), 64'd1);

    // 7. afull_value = 0 makes almost-full track full exactly
    do_reset();
    bus.afull_value = 5'd0;
    for (int i = 0; i < 32; i++) begin
      write_one(32'h7000 + i, 5'(i));
      check("af0_afull", 64'(bus.wr_almost_full), 64'((i + 1) == 32));
      check("af0_wfull", 64'(bus.wfull), 64'((i + 1) == 32));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-domain control half of the async FIFO. It is the counterpart of the read-side interface, whose signals are read_data, read_enable, aempty_value, rdempty, rd_almost_empty, underflow, fifo_read_count and rd_level. The block accepts write requests in the wclk domain and drives the dual-port memory write port. It publishes a Gray-coded write pointer for the read-domain synchronizer. It computes wfull, wr_almost_full, overflow, wr_level and fifo_write_count from a read pointer that is already synchronized into wclk.

Parameters:
DATA_WIDTH, 32, write data / memory word width
ADDR_WIDTH, 5, memory address width; DEPTH = 2**ADDR_WIDTH = 32; pointers are ADDR_WIDTH+1 bits

Ports:
wclk  input  1  write-domain clock; all logic on posedge
sw_rst  input  1  synchronous active-high reset
write_enable  input  1  write request
write_data  input  DATA_WIDTH  data to store
afull_value  input  ADDR_WIDTH  almost-full threshold in free slots
rptr_gray_sync  input  ADDR_WIDTH+1  read pointer (Gray), pre-synchronized into wclk
mem_we  output  1  memory write strobe
mem_waddr  output  ADDR_WIDTH  memory write address
mem_wdata  output  DATA_WIDTH  memory write data
wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer for the read-domain synchronizer
wfull  output  1  FIFO full
wr_almost_full  output  1  almost-full flag
overflow  output  1  one-cycle pulse: write attempted while full
wr_level  output  ADDR_WIDTH+1  occupancy as seen from the write domain
fifo_write_count  output  ADDR_WIDTH+1  accepted writes since reset, modulo 2**(ADDR_WIDTH+1)

Behaviour:
- Reset (sw_rst=1 at posedge) has priority over every other event. It clears to 0: wptr_bin, wptr_gray, wfull, wr_almost_full, overflow, wr_level and fifo_write_count.
- No write is accepted in a reset cycle: mem_we=0 whenever sw_rst=1.
- Write acceptance is combinational: accept = write_enable & ~wfull & ~sw_rst.
  - mem_we = accept.
  - mem_waddr = wptr_bin[ADDR_WIDTH-1:0].
  - mem_wdata = write_data.
  - The memory captures the word on the same posedge.
- Pointer update:
  - wptr_bin_next = wptr_bin + accept, wrapping modulo 2**(ADDR_WIDTH+1).
  - wptr_gray registers bin2gray(wptr_bin_next), i.e. (b>>1)^b.
  - wptr_gray changes by exactly one bit per accepted write.
- Read pointer: rptr_bin = gray2bin(rptr_gray_sync), combinational prefix XOR from the MSB.
- Level: level_next = wptr_bin_next - rptr_bin, computed modulo 2**(ADDR_WIDTH+1), range 0..DEPTH. wr_level is level_next registered.
- Flags are registered and look-ahead, computed from next-state values:
  - wfull <= (wptr_gray_next == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}), which is equivalent to level_next == DEPTH.
  - wfull therefore asserts on the same edge that accepts the DEPTH-th outstanding word.
  - wr_almost_full <= ((DEPTH - level_next) <= afull_value).
  - afull_value = 0 makes wr_almost_full identical to wfull.
  - afull_value is sampled every cycle; a change takes effect on the next edge.
- overflow <= write_enable & wfull & ~sw_rst. It is a single-cycle pulse per offending cycle, not sticky. Back-to-back illegal writes give back-to-back pulses. Pointer, memory and count are unchanged on an overflow.
- fifo_write_count <= fifo_write_count + accept, wrapping at 2**(ADDR_WIDTH+1).
- Full release: when rptr_gray_sync advances, wfull and wr_level update on the next posedge. The one-cycle pessimism is inherent and allowed. A write presented in the cycle where wfull=1 is rejected even if rptr_gray_sync has just advanced.
- Pointer wrap: correct across the 2*DEPTH boundary (wptr_bin 63 -> 0). Full detection relies on the MSB difference, not on magnitude.
- Reset mid-operation: all state returns to empty next edge. The read domain is reset by the same sw_rst sequencing (handled outside this block).

Test Plan:
1. Reset, then idle -> after the edge: wfull=0, wr_almost_full=0, overflow=0, wr_level=0, fifo_write_count=0, wptr_gray=0, mem_we=0.
2. rptr_gray_sync=0, afull_value=4; 32 consecutive writes of 0x1000+i:
   - mem_waddr runs 0..31.
   - wr_almost_full=1 from the edge accepting write 28 (wr_level=28).
   - wfull=1 on the edge accepting write 32; wr_level=32, fifo_write_count=32, wptr_gray=6'b110000.
3. FIFO full; hold write_enable for 3 cycles -> mem_we=0, overflow=1 for 3 consecutive cycles, wptr unchanged, fifo_write_count stays 32.
4. From full, set rptr_gray_sync=gray(4)=6'b000110 -> next edge wfull=0, wr_level=28, wr_almost_full=1. Then 4 more writes -> mem_waddr 0..3, wfull=1 again.
5. Wrap: drive pointers through 64 writes with reads tracking (rptr_gray_sync follows wptr-2) -> wptr_gray goes 6'b100000 -> 6'b000000 at wrap, wfull never asserts, wr_level holds 2.
6. sw_rst=1 concurrent with write_enable=1 at level 17 -> mem_we=0 that cycle; next edge all outputs at reset values; first subsequent write lands at mem_waddr=0.
